// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM state encoding and error flag bit positions.
package sram_responder_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } state_e;

   localparam int ADDR_W   = 12;
   localparam int ERR_W    = 3;
   localparam int ERR_ADDR = 2;
   localparam int ERR_RW   = 1;
   localparam int ERR_DROP = 0;

endpackage

// File: rtl/sram_responder_flex_counter.sv
// Up-counter with programmable rollover value, synchronous clear and count enable.
module sram_responder_flex_counter #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             count_enable_i,
   input  logic [WIDTH-1:0] rollover_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             rollover_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Wraps to zero on the enabled cycle that sits at the rollover value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_enable_i) begin
         if (count_q == rollover_val_i) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign rollover_o = (count_q == rollover_val_i);

endmodule

// File: rtl/sram_responder.sv
// Single-port word array with registered reads, a zero-fill INIT sweep and sticky error flags.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int DEPTH     = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 r_enable,
   input  logic                 w_enable,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [BUS_WIDTH-1:0] sram_i,
   output logic [BUS_WIDTH-1:0] sram_o,
   input  logic                 init_req,
   output logic                 busy,
   output logic                 rd_valid,
   output logic [ERR_W-1:0]     err,
   input  logic                 err_clr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BUS_WIDTH-1:0] mem [DEPTH];

   state_e               state_q, state_d;
   logic [BUS_WIDTH-1:0] sram_q;
   logic                 rdValid_q;
   logic [ERR_W-1:0]     err_q, err_d;

   logic [ADDR_W-1:0]    sweepCnt;
   logic                 sweepLast;
   logic                 sweepEn;
   logic                 addrOk;
   logic [AW-1:0]        memIdx;
   logic                 memWe;
   logic [AW-1:0]        memAddr;
   logic [BUS_WIDTH-1:0] memData;
   logic                 rdHit;
   logic                 rdBad;
   logic [ERR_W-1:0]     newErr;
   logic                 unusedSweep;

   // The counter is parked at zero in IDLE so every sweep starts from location 0.
   sram_responder_flex_counter #(
      .WIDTH(ADDR_W)
   ) u_sweep (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (state_q == ST_IDLE),
      .count_enable_i(sweepEn),
      .rollover_val_i(ADDR_W'(DEPTH - 1)),
      .count_o       (sweepCnt),
      .rollover_o    (sweepLast)
   );

   assign unusedSweep = ^sweepCnt;
   assign addrOk      = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
   assign memIdx      = addr[AW-1:0];

   always_comb begin
      state_d = state_q;
      sweepEn = 1'b0;
      memWe   = 1'b0;
      memAddr = memIdx;
      memData = sram_i;
      rdHit   = 1'b0;
      rdBad   = 1'b0;
      newErr  = '0;
      if (state_q == ST_INIT) begin
         sweepEn = 1'b1;
         memWe   = 1'b1;
         memAddr = sweepCnt[AW-1:0];
         memData = '0;
         if (sweepLast) begin
            state_d = ST_IDLE;
         end
         if (r_enable || w_enable) begin
            newErr[ERR_DROP] = 1'b1;
         end
      end else begin
         if (init_req) begin
            state_d = ST_INIT;
         end
         // A simultaneous read and write keeps the write and discards the read.
         if (r_enable || w_enable) begin
            if (!addrOk) begin
               newErr[ERR_ADDR] = 1'b1;
               rdBad            = r_enable && !w_enable;
            end else if (w_enable) begin
               memWe          = 1'b1;
               newErr[ERR_RW] = r_enable;
            end else begin
               rdHit = 1'b1;
            end
         end
      end
   end

   assign err_d = err_clr ? newErr : (err_q | newErr);

   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[memAddr] <= memData;
      end
   end

   // Array contents are deliberately left out of reset; the INIT sweep clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_INIT;
         sram_q    <= '0;
         rdValid_q <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         rdValid_q <= rdHit || rdBad;
         err_q     <= err_d;
         if (rdHit) begin
            sram_q <= mem[memIdx];
         end else if (rdBad) begin
            sram_q <= '0;
         end
      end
   end

   assign sram_o   = sram_q;
   assign rd_valid = rdValid_q;
   assign err      = err_q;
   assign busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard-based bench for sram_responder: reads push expected data, a monitor pops on rd_valid.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_enable = 1'b0;
   logic        w_enable = 1'b0;
   logic [11:0] addr = '0;
   logic [7:0]  sram_i = '0;
   logic [7:0]  sram_o;
   logic        init_req = 1'b0;
   logic        busy;
   logic        rd_valid;
   logic [2:0]  err;
   logic        err_clr = 1'b0;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  model [1024];
   logic [7:0]  expQ [$];
   logic [7:0]  lastRead = 8'h00;

   sram_responder #(
      .BUS_WIDTH(8),
      .DEPTH    (1024)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .r_enable(r_enable),
      .w_enable(w_enable),
      .addr    (addr),
      .sram_i  (sram_i),
      .sram_o  (sram_o),
      .init_req(init_req),
      .busy    (busy),
      .rd_valid(rd_valid),
      .err     (err),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every rd_valid pulse must match the oldest outstanding read.
   always @(posedge clk) begin
      #2;
      if (rd_valid === 1'b1) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_rd_valid got rd_valid=1 sram_o=%h required no pulse", sram_o);
         end else begin
            automatic logic [7:0] e = expQ.pop_front();
            if (sram_o !== e) begin
               bad++;
               $display("[TB] FAIL read_data got %h required %h", sram_o, e);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zeroModel();
      for (int i = 0; i < 1024; i++) model[i] = 8'h00;
   endtask

   task automatic doWrite(input int a, input logic [7:0] d);
      addr     = 12'(a);
      sram_i   = d;
      w_enable = 1'b1;
      step();
      w_enable = 1'b0;
      if (a < 1024) model[a] = d;
   endtask

   task automatic doRead(input int a);
      automatic logic [7:0] e = (a < 1024) ? model[a] : 8'h00;
      addr     = 12'(a);
      r_enable = 1'b1;
      expQ.push_back(e);
      lastRead = e;
      step();
      r_enable = 1'b0;
   endtask

   task automatic drain(input string name);
      step();
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_outstanding got %0d pending reads required 0", name, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic waitSweep(input string name, input int startCnt);
      automatic int cnt = startCnt;
      while (busy === 1'b1 && cnt < 2000) begin
         step();
         cnt++;
      end
      total++;
      if (cnt != 1024) begin
         bad++;
         $display("[TB] FAIL %s_sweep_len got %0d cycles required 1024", name, cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy got %b required 1", busy); end
      total++;
      if (sram_o !== 8'h00) begin bad++; $display("[TB] FAIL rst_sram_o got %h required 00", sram_o); end
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_valid got %b required 0", rd_valid); end
      total++;
      if (err !== 3'b000) begin bad++; $display("[TB] FAIL rst_err got %b required 000", err); end
      rst = 1'b0;
      zeroModel();
      waitSweep("rst", 0);
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_after got %b required 0", busy); end
      doRead(0);
      doRead(511);
      doRead(1023);
      drain("rst");
   endtask

   task automatic test_write_read();
      doWrite(5, 8'hA5);
      addr     = 12'd5;
      r_enable = 1'b1;
      expQ.push_back(8'hA5);
      lastRead = 8'hA5;
      step();
      r_enable = 1'b0;
      total++;
      if (rd_valid !== 1'b1 || sram_o !== 8'hA5) begin
         bad++;
         $display("[TB] FAIL wr_rd_latency got rd_valid=%b sram_o=%h required 1/a5", rd_valid, sram_o);
      end
      drain("wr_rd");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) doWrite(100 + i * 37, 8'($urandom_range(0, 255)));
      doWrite(1023, 8'hFF);
      doWrite(0, 8'h01);
      for (int i = 0; i < 8; i++) doRead(100 + i * 37);
      doRead(1023);
      doRead(0);
      for (int i = 0; i < 4; i++) begin
         doWrite(600 + i, 8'(8'h10 * i + 8'h0F));
         doRead(600 + i);
      end
      drain("b2b");
      step();
      total++;
      if (sram_o !== lastRead || rd_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL hold got sram_o=%h rd_valid=%b required %h/0", sram_o, rd_valid, lastRead);
      end
   endtask

   task automatic test_rw_conflict();
      addr     = 12'd7;
      sram_i   = 8'h3C;
      r_enable = 1'b1;
      w_enable = 1'b1;
      model[7] = 8'h3C;
      step();
      r_enable = 1'b0;
      w_enable = 1'b0;
      step();
      total++;
      if (err !== 3'b010) begin bad++; $display("[TB] FAIL rw_conflict_err got %b required 010", err); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      doRead(7);
      drain("rw_conflict");
   endtask

   task automatic test_addr_err();
      doRead(1024);
      total++;
      if (err !== 3'b100) begin bad++; $display("[TB] FAIL addr_err got %b required 100", err); end
      drain("addr_err");
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      total++;
      if (err !== 3'b000) begin bad++; $display("[TB] FAIL err_clr got %b required 000", err); end
      addr     = 12'd2000;
      sram_i   = 8'h77;
      w_enable = 1'b1;
      err_clr  = 1'b1;
      step();
      w_enable = 1'b0;
      err_clr  = 1'b0;
      total++;
      if (err !== 3'b100) begin bad++; $display("[TB] FAIL clr_and_new_err got %b required 100", err); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_init_sweep();
      automatic int cnt = 0;
      for (int i = 0; i < 16; i++) doWrite(i, 8'(i + 8'h40));
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      zeroModel();
      while (busy === 1'b1 && cnt < 2000) begin
         if (cnt == 10) begin
            addr = 12'd3; sram_i = 8'hEE; w_enable = 1'b1;
         end else if (cnt == 11) begin
            w_enable = 1'b0;
            init_req = 1'b1;
            total++;
            if (err !== 3'b001) begin bad++; $display("[TB] FAIL drop_err got %b required 001", err); end
         end else if (cnt == 12) begin
            init_req = 1'b0;
         end else if (cnt == 20) begin
            addr = 12'd4; r_enable = 1'b1;
         end else if (cnt == 21) begin
            r_enable = 1'b0;
         end
         step();
         cnt++;
      end
      total++;
      if (cnt != 1024) begin bad++; $display("[TB] FAIL init_sweep_len got %0d cycles required 1024", cnt); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      for (int i = 0; i < 1024; i++) doRead(i);
      drain("init_sweep");
   endtask

   task automatic test_reset_midsweep();
      automatic int cnt = 0;
      doWrite(20, 8'h5A);
      doRead(20);
      drain("pre_midrst");
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      zeroModel();
      while (cnt < 500) begin
         w_enable = (cnt == 100);
         step();
         cnt++;
      end
      total++;
      if (err !== 3'b001 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL pre_midrst got err=%b busy=%b required 001/1", err, busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b1 || sram_o !== 8'h00 || rd_valid !== 1'b0 || err !== 3'b000) begin
         bad++;
         $display("[TB] FAIL midrst_outputs got busy=%b sram_o=%h rd_valid=%b err=%b required 1/00/0/000",
                  busy, sram_o, rd_valid, err);
      end
      step();
      step();
      rst = 1'b0;
      waitSweep("midrst", 0);
      doRead(20);
      doRead(1023);
      drain("midrst");
   endtask

   initial begin
      $display("[TB] starting sram_responder bench");
      test_reset();
      test_write_read();
      test_back_to_back();
      test_rw_conflict();
      test_addr_err();
      test_init_sweep();
      test_reset_midsweep();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of stored words (power of two, at most 4096).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port r_enable, input, 1, read request for addr this cycle.
REQ-006 SHALL have port w_enable, input, 1, write request of sram_i to addr this cycle.
REQ-007 SHALL have port addr, input, 12, word address.
REQ-008 SHALL have port sram_i, input, BUS_WIDTH, write data.
REQ-009 SHALL have port sram_o, output, BUS_WIDTH, registered read data.
REQ-010 SHALL have port init_req, input, 1, single-cycle request to zero-fill the whole array.
REQ-011 SHALL have port busy, output, 1, high while the zero-fill sweep runs.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse when sram_o carries new read data.
REQ-013 SHALL have port err, output, 3, sticky error flags {addr_err, rw_conflict, drop_err}.
REQ-014 SHALL have port err_clr, input, 1, clears all err bits.

Function
REQ-015 SHALL implement a two-state FSM: INIT and IDLE.
REQ-016 SHALL, in INIT, write zero to one location per cycle at sweep counter 0..DEPTH-1, with busy=1.
REQ-017 SHALL leave INIT for IDLE on the cycle after writing location DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-018 SHALL enter INIT from IDLE on init_req=1; init_req during INIT SHALL be ignored and SHALL NOT restart the sweep.
REQ-019 SHALL, in IDLE with w_enable=1 and addr<DEPTH, store sram_i at addr on that clock edge.
REQ-020 SHALL, in IDLE with r_enable=1, w_enable=0 and addr<DEPTH, load mem[addr] into sram_o one cycle later and pulse rd_valid in that same cycle.
REQ-021 SHALL hold sram_o unchanged when no read completes.
REQ-022 SHALL, when r_enable and w_enable are both 1, perform the write only, produce no read, and set rw_conflict.
REQ-023 SHALL, when addr>=DEPTH and either enable is 1, perform no access, set addr_err, and on a read pulse rd_valid with sram_o=0.
REQ-024 SHALL, when r_enable or w_enable is 1 during INIT, drop the request (no access, no rd_valid) and set drop_err.
REQ-025 SHALL keep err bits set until err_clr=1; if err_clr and a new error occur in the same cycle, the new error bit SHALL be set.
REQ-026 SHALL make a write followed next cycle by a read of the same address return the newly written data.

Reset
REQ-027 SHALL, on rst, force sram_o=0, rd_valid=0, err=0, sweep counter=0, and state=INIT with busy=1.
REQ-028 SHALL NOT reset array contents directly; the INIT sweep after rst releases zero-fills the array.
REQ-029 SHALL abort a sweep when rst asserts mid-INIT and restart it from location 0 after release.

Structure
REQ-030 SHALL take the FSM state enum and the err bit-index constants from the shared project package.
REQ-031 SHALL use the existing flex counter sub-module, 12 bits, rollover DEPTH-1, as the INIT sweep counter; the array SHALL be inferred in this module.

Verification
REQ-032 SHALL check reset release: busy=1 for exactly 1024 cycles, then 0; reads of addr 0, 511 and 1023 return 0x00.
REQ-033 SHALL check write 0xA5 to addr 5, then read addr 5 on the next cycle: sram_o=0xA5 with rd_valid one cycle after the read request.
REQ-034 SHALL check r_enable=w_enable=1 at addr 7 with data 0x3C: no rd_valid, err=3'b010, and a later read of addr 7 returns 0x3C.
REQ-035 SHALL check a read of addr 1024: sram_o=0x00, rd_valid=1, err=3'b100; then err_clr gives err=0.
REQ-036 SHALL check init_req after data fill: write attempted at cycle 10 of the sweep sets err=3'b001 and is dropped; all locations read 0x00 after busy falls.
REQ-037 SHALL check rst asserted at sweep cycle 500: outputs take reset values immediately, and a full 1024-cycle sweep follows release.
